// File: rtl/lm80c_rst_pkg.sv
// Shared types for the PLL-lock driven reset sequencer.
package lm80c_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_STAGE,
    ST_RUN,
    ST_SOFT
  } rst_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lm80c_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module lm80c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff <= '0;
    end else begin
      r_ff <= {r_ff[0], i_d};
    end
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/pll_reset_seq.sv
// Staged peripheral/CPU reset release gated on a stable PLL lock.
// Define PLL_RESET_SEQ_LOSSCNT_EN to build the lock-loss counter.
module pll_reset_seq
  import lm80c_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int SOFT_PULSE         = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic                  rst_periph,
  output logic                  rst_cpu,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int MAXP = max3(LOCK_STABLE_CYCLES,
                             STAGE_GAP, SOFT_PULSE);
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] STABLE_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] SOFT_LAST =
    CW'(SOFT_PULSE - 1);

  logic          w_locked_s;
  logic          w_lost;
  rst_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rst_periph;
  logic          r_rst_cpu;
  logic          r_ready;

  lm80c_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_locked_s)
  );

  // Lock loss outranks every other transition, soft requests included.
  assign w_lost = !w_locked_s &&
                  (r_state != ST_WAIT_LOCK);

  always_ff @(posedge clk) begin
    if (rst || w_lost) begin
      r_state      <= ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_rst_periph <= 1'b1;
      r_rst_cpu    <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end
        end
        ST_STABLE: begin
          if (r_cnt == STABLE_LAST) begin
            r_state      <= ST_STAGE;
            r_cnt        <= '0;
            r_rst_periph <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STAGE: begin
          if (r_cnt == GAP_LAST) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_rst_cpu <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (soft_rst_req) begin
            r_state   <= ST_SOFT;
            r_cnt     <= '0;
            r_rst_cpu <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        ST_SOFT: begin
          if (r_cnt == SOFT_LAST) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_rst_cpu <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= ST_WAIT_LOCK;
          r_cnt        <= '0;
          r_rst_periph <= 1'b1;
          r_rst_cpu    <= 1'b1;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign rst_periph = r_rst_periph;
  assign rst_cpu    = r_rst_cpu;
  assign ready      = r_ready;

`ifdef PLL_RESET_SEQ_LOSSCNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (w_lost && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
